pad_ctrl: RTL and testbench
===========================

# pad_ctrl

Paddle timing controller that replaces the two potentiometer-driven 555 one-shots feeding the paddle block's PAD1_OUT/PAD2_OUT inputs. Once per frame it raises both pad-timer outputs on vertical reset and drops each one after a line count set by that player's position. The line count comes from a per-player position register driven by digital up/down controls, or from sampled analog values when that option is compiled in. The block sits between player input logic and the paddle block, and runs in the CLK_DRV domain; original video timing signals are sampled as data and edge-detected.

## Interface
Parameters:
- MIN_LINES, 16: lines added to the position to form the pulse length (must be ≥1).
- POS_MAX, 200: maximum position value (must be ≤255).
- STEP, 2: position change per frame per held control.

Ports:
- CLK_DRV  in  1  fast drive clock; all state on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- VRESET  in  1  vertical reset level from sync generator; rising edge starts a frame.
- HSYNC_N  in  1  horizontal sync, active low; falling edge counts one line.
- ATTRACT_N  in  1  low = attract mode; positions frozen.
- UP1, DN1, UP2, DN2  in  1 each  player controls, active high.
- POS1_IN, POS2_IN  in  8 each  analog position samples; used only with PAD_ANALOG_EN.
- PAD1_OUT, PAD2_OUT  out  1 each  pad timer pulses to the paddle block.
- POS1, POS2  out  8 each  current position registers.

## Operation
- Edge detect: previous-sample registers for VRESET and HSYNC_N.
  - VRISE = VRESET & ~VRESET_q.
  - HFALL = ~HSYNC_N & HSYNC_q.
- Position update happens only on the VRISE cycle, and only if ATTRACT_N=1.
  - UP only: pos = min(pos+STEP, POS_MAX).
  - DN only: pos = pos−STEP, saturating at 0.
  - Both or neither: hold.
  - Arithmetic is 9-bit before the clamp, so no wrap is possible.
- Target latch: on VRISE, target = MIN_LINES + updated pos, held in 9 bits. The same-cycle updated value is used.
- Per-channel FSM with two states, IDLE and TIMING:
  - IDLE → TIMING on VRISE: line counter cleared to 0, PAD_OUT goes 1.
  - TIMING on HFALL: counter increments. When the incremented value equals target, go to IDLE with PAD_OUT 0.
  - TIMING on VRISE (frame shorter than pulse): restart. Counter goes to 0, new target is latched, PAD_OUT stays 1.
- Simultaneous VRISE and HFALL: VRISE wins and the HFALL is not counted.
- The two channels are fully independent; they share only the edge detectors.
- Attract mode gates position updates only. Timing pulses continue, and paddle visibility is handled downstream.

## Timing
- Reset values:
  - PAD1_OUT=PAD2_OUT=0, both FSMs IDLE, counters 0, targets 0.
  - POS1=POS2=POS_MAX/2 (100 at default parameters).
  - VRESET_q=0 and HSYNC_q=1, so no spurious edge is seen after reset.
- Reset asserted mid-pulse: outputs drop to 0 on the next edge; no pulse occurs until the next VRISE after reset is released.
- Latency:
  - PAD_OUT rises one CLK_DRV cycle after the first cycle VRESET is sampled high.
  - PAD_OUT falls one CLK_DRV cycle after the cycle in which the HSYNC_N low sample completes line number target.
  - POS updates are visible on the cycle after VRISE.
- Pulse length: exactly target HFALLs after VRISE, with no dependence on CLK_DRV phase beyond one-cycle sampling.

## Configuration
- PAD_ANALOG_EN defined:
  - On VRISE (ATTRACT_N=1), pos = min(POSn_IN, POS_MAX).
  - UP/DN inputs are ignored.
- PAD_ANALOG_EN undefined:
  - The up/down accumulator described above is used.
  - POS1_IN/POS2_IN are ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then VRESET pulse, then 150 HSYNC_N pulses with no controls: POS1=POS2=100, and both PAD_OUT are high for exactly 116 lines, then low.
- Hold UP1 for 60 frames: POS1 saturates at 200 (never 201+), PAD1_OUT spans 216 lines, and POS2 stays at 100.
- Hold DN2 for 60 frames, then UP2 and DN2 together: POS2 reaches 0 with no wrap, PAD2_OUT spans 16 lines, and the combined press holds POS2 at 0.
- VRESET rising on the same cycle as an HSYNC_N fall, and a second VRESET at line 50 of a 116-line pulse: the coincident line is not counted, and the pulse restarts, ending 116 lines after the second VRESET.
- ATTRACT_N=0 with UP1 held for 10 frames: POS1 is unchanged at 100 and pulses continue at 116 lines. RESET asserted at line 30 drops PAD_OUT the next cycle.
- With PAD_ANALOG_EN, POS1_IN=255 and POS2_IN=37: POS1=200 and POS2=37 after the next VRESET, with pulses of 216 and 53 lines.

Source files
------------

// File: rtl/pad_ctrl.sv
// pad_ctrl -- paddle timing controller.
//
// Produces the two per-player pad-timer pulses once per frame. On the
// rising edge of VRESET both pulses start. Each one ends after
// MIN_LINES + POSn falling HSYNC_N edges. The per-player positions come from
// up/down controls (default build) or from sampled analog values
// (PAD_ANALOG_EN defined). The positions are frozen while ATTRACT_N is low.
//
// Optional feature macro: PAD_ANALOG_EN
//   defined   : on each frame start pos = min(POSn_IN, POS_MAX); UP/DN ignored
//   undefined : up/down accumulator with STEP per frame; POSn_IN ignored
//
// Ports:
//   CLK_DRV            in   drive clock, all state on rising edge
//   RESET              in   synchronous active-high reset
//   VRESET             in   vertical reset level (rising edge = frame start)
//   HSYNC_N            in   horizontal sync, active low (falling edge = line)
//   ATTRACT_N          in   low = attract mode, positions frozen
//   UP1/DN1/UP2/DN2    in   player controls, active high
//   POS1_IN/POS2_IN    in   8-bit analog position samples
//   PAD1_OUT/PAD2_OUT  out  pad timer pulses
//   POS1/POS2          out  current position registers
//
// Channel FSM
//   state     | meaning
//   ST_IDLE   | no pulse, waiting for the frame start
//   ST_TIMING | pulse high, counting lines up to the latched target
module pad_ctrl #(
  parameter int MIN_LINES = 16,
  parameter int POS_MAX   = 200,
  parameter int STEP      = 2
) (
  input  logic       CLK_DRV,
  input  logic       RESET,
  input  logic       VRESET,
  input  logic       HSYNC_N,
  input  logic       ATTRACT_N,
  input  logic       UP1,
  input  logic       DN1,
  input  logic       UP2,
  input  logic       DN2,
  input  logic [7:0] POS1_IN,
  input  logic [7:0] POS2_IN,
  output logic       PAD1_OUT,
  output logic       PAD2_OUT,
  output logic [7:0] POS1,
  output logic [7:0] POS2
);

  localparam logic [8:0] MIN9     = 9'(MIN_LINES);
  localparam logic [8:0] POS_MAX9 = 9'(POS_MAX);
  localparam logic [7:0] POS_MAX8 = 8'(POS_MAX);
  localparam logic [7:0] POS_RST  = 8'(POS_MAX / 2);

  typedef enum logic {ST_IDLE, ST_TIMING} state_t;

  logic       vreset_q, vreset_d;
  logic       hsync_q, hsync_d;
  logic       vrise, hfall;

  state_t     state_q [2];
  state_t     state_d [2];
  logic [7:0] pos_q   [2];
  logic [7:0] pos_d   [2];
  logic [7:0] pos_upd [2];
  logic [8:0] cnt_q   [2];
  logic [8:0] cnt_d   [2];
  logic [8:0] tgt_q   [2];
  logic [8:0] tgt_d   [2];
  logic       pad_q   [2];
  logic       pad_d   [2];

  assign vreset_d = VRESET;
  assign hsync_d  = HSYNC_N;
  assign vrise    = VRESET & ~vreset_q;
  assign hfall    = ~HSYNC_N & hsync_q;

`ifdef PAD_ANALOG_EN
  logic [7:0] pos_in [2];
  logic       unused_ctrl;
  assign pos_in[0]   = POS1_IN;
  assign pos_in[1]   = POS2_IN;
  assign unused_ctrl = ^{UP1, DN1, UP2, DN2};
`else
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [7:0] STEP8 = 8'(STEP);
  logic [1:0] up, dn;
  logic [8:0] sum_up [2];
  logic       unused_pos_in;
  assign up            = {UP2, UP1};
  assign dn            = {DN2, DN1};
  assign unused_pos_in = ^{POS1_IN, POS2_IN};
`endif

  // Position that applies from this frame start onward.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pos_upd[i] = pos_q[i];
`ifdef PAD_ANALOG_EN
      pos_upd[i] = (pos_in[i] > POS_MAX8) ? POS_MAX8 : pos_in[i];
`else
      // 9-bit sum so a step past 255 cannot wrap before the clamp.
      sum_up[i] = {1'b0, pos_q[i]} + STEP9;
      if (up[i] && !dn[i])
        pos_upd[i] = (sum_up[i] > POS_MAX9) ? POS_MAX8 : sum_up[i][7:0];
      else if (dn[i] && !up[i])
        pos_upd[i] = ({1'b0, pos_q[i]} < STEP9) ? 8'd0 : pos_q[i] - STEP8;
`endif
      pos_d[i] = (vrise && ATTRACT_N) ? pos_upd[i] : pos_q[i];
    end
  end

  // A frame start takes priority over a coincident line edge, which is dropped.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt_d[i]   = tgt_q[i];
      pad_d[i]   = pad_q[i];
      if (vrise) begin
        state_d[i] = ST_TIMING;
        cnt_d[i]   = 9'd0;
        tgt_d[i]   = MIN9 + {1'b0, pos_d[i]};
        pad_d[i]   = 1'b1;
      end else if (state_q[i] == ST_TIMING && hfall) begin
        cnt_d[i] = cnt_q[i] + 9'd1;
        if (cnt_q[i] + 9'd1 == tgt_q[i]) begin
          state_d[i] = ST_IDLE;
          pad_d[i]   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_DRV) begin
    if (RESET) begin
      vreset_q <= 1'b0;
      hsync_q  <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_IDLE;
        pos_q[i]   <= POS_RST;
        cnt_q[i]   <= 9'd0;
        tgt_q[i]   <= 9'd0;
        pad_q[i]   <= 1'b0;
      end
    end else begin
      vreset_q <= vreset_d;
      hsync_q  <= hsync_d;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        pos_q[i]   <= pos_d[i];
        cnt_q[i]   <= cnt_d[i];
        tgt_q[i]   <= tgt_d[i];
        pad_q[i]   <= pad_d[i];
      end
    end
  end

  assign PAD1_OUT = pad_q[0];
  assign PAD2_OUT = pad_q[1];
  assign POS1     = pos_q[0];
  assign POS2     = pos_q[1];

endmodule

// File: tb/tb_pad_ctrl.sv
// tb_pad_ctrl -- self-checking bench for pad_ctrl.
// A frame-level reference model (integer positions, line counts since the
// frame start) predicts both pad outputs every clock and positions per frame.
module tb_pad_ctrl;

  logic       clk = 1'b0;
  logic       rst, vres, hs_n, attr_n;
  logic       up1, dn1, up2, dn2;
  logic [7:0] p1_in, p2_in;
  logic       pad1, pad2;
  logic [7:0] pos1, pos2;

  always #5 clk = ~clk;

  pad_ctrl dut (
    .CLK_DRV  (clk),
    .RESET    (rst),
    .VRESET   (vres),
    .HSYNC_N  (hs_n),
    .ATTRACT_N(attr_n),
    .UP1      (up1),
    .DN1      (dn1),
    .UP2      (up2),
    .DN2      (dn2),
    .POS1_IN  (p1_in),
    .POS2_IN  (p2_in),
    .PAD1_OUT (pad1),
    .PAD2_OUT (pad2),
    .POS1     (pos1),
    .POS2     (pos2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  int m_pos [2];
  int m_tgt [2];
  int m_lines [2];
  bit m_pad [2];
  bit m_pv, m_ph;
  int line_no;          // lines since last frame start
  int fall_line [2];    // line number at which the DUT pulse was seen to end
  bit prev_dut_pad [2];

  function automatic int new_pos(input int pos, input bit u, input bit d, input int ain);
`ifdef PAD_ANALOG_EN
    return (ain > 200) ? 200 : ain;
`else
    if (u && !d) return (pos + 2 > 200) ? 200 : pos + 2;
    if (d && !u) return (pos - 2 < 0) ? 0 : pos - 2;
    return pos;
`endif
  endfunction

  task automatic cyc();
    bit vr, hf;
    bit dp [2];
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_pos[i] = 100; m_tgt[i] = 0; m_lines[i] = 0; m_pad[i] = 0;
      end
      m_pv = 0; m_ph = 1;
    end else begin
      vr = vres && !m_pv;
      hf = !hs_n && m_ph;
      if (vr) begin
        if (attr_n) begin
          m_pos[0] = new_pos(m_pos[0], up1, dn1, int'(p1_in));
          m_pos[1] = new_pos(m_pos[1], up2, dn2, int'(p2_in));
        end
        for (int i = 0; i < 2; i++) begin
          m_tgt[i] = 16 + m_pos[i]; m_lines[i] = 0; m_pad[i] = 1;
          fall_line[i] = -1;
        end
        line_no = 0;
      end else if (hf) begin
        line_no++;
        for (int i = 0; i < 2; i++)
          if (m_pad[i]) begin
            m_lines[i]++;
            if (m_lines[i] == m_tgt[i]) m_pad[i] = 0;
          end
      end
      m_pv = vres; m_ph = hs_n;
    end
    chk("pad1", 32'(pad1), 32'(m_pad[0]));
    chk("pad2", 32'(pad2), 32'(m_pad[1]));
    dp[0] = pad1; dp[1] = pad2;
    for (int i = 0; i < 2; i++) begin
      if (prev_dut_pad[i] && !dp[i]) fall_line[i] = line_no;
      prev_dut_pad[i] = dp[i];
    end
  endtask

  task automatic check_pos();
    chk("pos1_model", 32'(pos1), 32'(m_pos[0]));
    chk("pos2_model", 32'(pos2), 32'(m_pos[1]));
  endtask

  task automatic vpulse();
    vres = 1'b1; cyc(); check_pos(); cyc(); vres = 1'b0;
  endtask

  task automatic line();
    hs_n = 1'b0; cyc(); hs_n = 1'b1; cyc();
  endtask

  task automatic frame(input int n);
    vpulse();
    repeat (n) line();
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(); cyc(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vres = 1'b0; hs_n = 1'b1; attr_n = 1'b1;
    up1 = 0; dn1 = 0; up2 = 0; dn2 = 0;
    p1_in = 8'd0; p2_in = 8'd0;
    line_no = 0;
    for (int i = 0; i < 2; i++) begin
      fall_line[i] = -1; prev_dut_pad[i] = 0;
    end
    repeat (3) cyc();
    chk("rst_pad1", 32'(pad1), 0);
    chk("rst_pad2", 32'(pad2), 0);
    chk("rst_pos1", 32'(pos1), 100);
    chk("rst_pos2", 32'(pos2), 100);
    rst = 1'b0;
    cyc();

`ifndef PAD_ANALOG_EN
    // Baseline frame
    frame(150);
    chk("base_pos1", 32'(pos1), 100);
    chk("base_pos2", 32'(pos2), 100);
    chk("base_len1", 32'(fall_line[0]), 116);
    chk("base_len2", 32'(fall_line[1]), 116);

    // UP1 saturation, POS2 untouched
    up1 = 1'b1;
    repeat (59) frame(10);
    frame(230);
    up1 = 1'b0;
    chk("up_pos1", 32'(pos1), 200);
    chk("up_pos2", 32'(pos2), 100);
    chk("up_len1", 32'(fall_line[0]), 216);
    chk("up_len2", 32'(fall_line[1]), 116);

    // DN2 to zero, then both pressed
    dn2 = 1'b1;
    repeat (59) frame(10);
    frame(40);
    chk("dn_pos2", 32'(pos2), 0);
    chk("dn_len2", 32'(fall_line[1]), 16);
    up2 = 1'b1;
    frame(40);
    chk("both_pos2", 32'(pos2), 0);
    chk("both_len2", 32'(fall_line[1]), 16);
    up2 = 1'b0; dn2 = 1'b0;
`endif

    // Coincident VRESET rise and HSYNC_N fall; then restart mid-pulse
    do_reset();
    vres = 1'b1; hs_n = 1'b0; cyc(); hs_n = 1'b1; cyc(); vres = 1'b0;
    repeat (130) line();
    chk("coinc_len1", 32'(fall_line[0]), 116);
    vpulse();
    repeat (50) line();
    chk("mid_pad1", 32'(pad1), 1);
    vpulse();
    repeat (130) line();
    chk("restart_len1", 32'(fall_line[0]), 116);
    chk("restart_len2", 32'(fall_line[1]), 116);

    // Attract mode freezes positions, pulses continue
    attr_n = 1'b0; up1 = 1'b1; p1_in = 8'd255; p2_in = 8'd37;
    repeat (9) frame(10);
    frame(130);
    chk("attr_pos1", 32'(pos1), 100);
    chk("attr_len1", 32'(fall_line[0]), 116);
    attr_n = 1'b1; up1 = 1'b0;

    // Reset mid-pulse
    vpulse();
    repeat (30) line();
    rst = 1'b1; cyc();
    chk("rst_mid_pad1", 32'(pad1), 0);
    chk("rst_mid_pad2", 32'(pad2), 0);
    cyc(); rst = 1'b0;
    repeat (5) line();
    chk("post_rst_pad1", 32'(pad1), 0);

`ifdef PAD_ANALOG_EN
    p1_in = 8'd255; p2_in = 8'd37;
    frame(230);
    chk("ana_pos1", 32'(pos1), 200);
    chk("ana_pos2", 32'(pos2), 37);
    chk("ana_len1", 32'(fall_line[0]), 216);
    chk("ana_len2", 32'(fall_line[1]), 53);
`endif

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      {up1, dn1, up2, dn2} = 4'($urandom_range(0, 15));
      attr_n = ($urandom_range(0, 7) != 0);
      p1_in = 8'($urandom_range(0, 255));
      p2_in = 8'($urandom_range(0, 255));
      vres = 1'b1;
      hs_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      cyc(); check_pos();
      hs_n = 1'b1; cyc(); vres = 1'b0;
      repeat ($urandom_range(0, 240)) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        line();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
